// File: rtl/uart_tx_pkg.sv
// Shared UART TX types: FSM state encoding and parity-type constants.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Frame request / serializer / line bundle between the UART TX controller and its environment.
interface uart_tx_ctrl_if #(parameter int WIDTH = 8);

  logic [WIDTH-1:0] P_DATA;
  logic             Data_Valid;
  logic             PAR_EN;
  logic             PAR_TYP;
  logic             ser_out;
  logic             ser_done;
  logic             ser_en;
  logic             Busy;
  logic             TX_OUT;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_out, ser_done,
    input  ser_en, Busy, TX_OUT
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_out, ser_done,
    output ser_en, Busy, TX_OUT
  );

endinterface

// File: rtl/uart_tx_ctrl_parity.sv
// Registered parity generator; the parity type is folded into the stored bit at capture.
module parity_calc
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  input  logic             cap,
  output logic             parity
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   parity <= 1'b0;
    else if (cap) parity <= (^data) ^ (par_typ == PAR_ODD);
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit framing FSM: start bit, serializer data bits, optional parity, stop bit.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_tx_ctrl_if.slave bus
);

  state_t state, state_nx;
  logic   busy_q;
  logic   par_en_q;
  logic   parity_q;
  logic   accept;
  logic   tx;
  logic   sen;

  assign accept = (state == IDLE) && bus.Data_Valid;

  parity_calc #(.WIDTH(WIDTH)) u_parity (
    .clk     (CLK),
    .rst_n   (RST),
    .data    (bus.P_DATA),
    .par_typ (bus.PAR_TYP),
    .cap     (accept),
    .parity  (parity_q)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state  <= state_nx;
      busy_q <= (state_nx != IDLE);
      if (accept) par_en_q <= bus.PAR_EN;
    end
  end

  // STOP always returns to IDLE, guaranteeing one idle cycle between frames.
  always_comb begin
    state_nx = state;
    tx       = 1'b1;
    sen      = 1'b0;
    unique case (state)
      IDLE:    if (bus.Data_Valid) state_nx = START;
      START: begin
        tx       = 1'b0;
        state_nx = DATA;
      end
      DATA: begin
        tx  = bus.ser_out;
        sen = 1'b1;
        if (bus.ser_done) state_nx = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx       = parity_q;
        state_nx = STOP;
      end
      STOP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign bus.TX_OUT = tx;
  assign bus.ser_en = sen;
  assign bus.Busy   = busy_q;

endmodule
